// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel FSM states, register
// word offsets within a channel block and CTRL bit positions.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } chan_state_e;

    // Word offsets (paddr[3:2]) inside a 0x10-byte channel block
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CHAN_STRIDE = 16;

    localparam int unsigned CTRL_EN = 0;
    localparam int unsigned CTRL_AR = 1;
    localparam int unsigned CTRL_IE = 2;
    localparam int unsigned CTRL_W  = 3;

endpackage

// File: rtl/timer_bank_if.sv
// APB-style register bus between a host and the timer bank.
interface timer_bank_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_chan.sv
// One down-counter channel: CTRL/LOAD/STATUS registers, IDLE/LOAD/RUN/DONE
// sequencing on the shared tick, and a sticky interrupt flag.
module timer_chan
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              ctrl_we,
    input  logic              load_we,
    input  logic              status_clr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  load,
    output logic [WIDTH-1:0]  count,
    output logic              intr,
    output logic              irq
);

    chan_state_e      state, state_next;
    logic [WIDTH-1:0] count_next;
    logic             intr_set;
    logic             en;
    logic             auto_reload;

    assign en          = ctrl[CTRL_EN];
    assign auto_reload = ctrl[CTRL_AR];
    assign irq         = intr & ctrl[CTRL_IE];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            ctrl  <= '0;
            load  <= '0;
            count <= '0;
            intr  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (ctrl_we) ctrl <= wdata[CTRL_W-1:0];
            if (load_we) load <= wdata;
            // A terminal event in the same cycle as a W1C keeps the flag set
            if (intr_set)        intr <= 1'b1;
            else if (status_clr) intr <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        intr_set   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else begin
                    count_next = load;
                    if (load == '0) begin
                        intr_set   = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (count != '0) begin
                        count_next = count - 1'b1;
                    end else begin
                        intr_set = 1'b1;
                        if (auto_reload) count_next = load;
                        else             state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                count_next = '0;
                if (!en) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/timer_bank.sv
// Bank of independent down-counter timers behind an APB-style register bus,
// sharing one programmable prescaler tick.
module timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    timer_bank_if.slave       bus,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam logic [3:0] NCH = 4'(NUM_CH);

    logic             access;
    logic             wr;
    logic [3:0]       chan_idx;
    logic [1:0]       reg_sel;
    logic             chan_hit;
    logic             pre_hit;
    logic             tick;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [31:0]      rdata;

    logic [CTRL_W-1:0] ctrl_q  [NUM_CH];
    logic [WIDTH-1:0]  load_q  [NUM_CH];
    logic [WIDTH-1:0]  count_q [NUM_CH];
    logic [NUM_CH-1:0] intr_q;

    logic unused_bits;
    assign unused_bits = ^{bus.paddr[1:0], bus.pwdata};

    assign access   = bus.psel & bus.penable;
    assign wr       = access & bus.pwrite;
    assign chan_idx = bus.paddr[7:4];
    assign reg_sel  = bus.paddr[3:2];
    assign chan_hit = (chan_idx < NCH);
    assign pre_hit  = (chan_idx == NCH) && (reg_sel == 2'd0);

    // Tick fires when the count reaches PRESCALE, giving a period of PRESCALE+1
    assign tick = (pre_cnt == prescale);

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else if (wr && pre_hit) begin
            prescale <= bus.pwdata[PRE_W-1:0];
            pre_cnt  <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        logic sel;
        assign sel = wr && chan_hit && (chan_idx == 4'(i));

        timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .ctrl_we    (sel && (reg_sel == REG_CTRL)),
            .load_we    (sel && (reg_sel == REG_LOAD)),
            .status_clr (sel && (reg_sel == REG_STATUS) && bus.pwdata[0]),
            .wdata      (bus.pwdata[WIDTH-1:0]),
            .ctrl       (ctrl_q[i]),
            .load       (load_q[i]),
            .count      (count_q[i]),
            .intr       (intr_q[i]),
            .irq        (irq[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (access && !reset) begin
            if (pre_hit) begin
                rdata = 32'(prescale);
            end else begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (chan_hit && (chan_idx == 4'(i))) begin
                        case (reg_sel)
                            REG_CTRL:   rdata = 32'(ctrl_q[i]);
                            REG_LOAD:   rdata = 32'(load_q[i]);
                            REG_COUNT:  rdata = 32'(count_q[i]);
                            REG_STATUS: rdata = 32'(intr_q[i]);
                            default:    rdata = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.prdata  = rdata;
    assign bus.pready  = 1'b1;
    assign bus.pslverr = access && !reset && !chan_hit && !pre_hit;
    assign irq_any     = |irq;

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent down-counter channels (1..8).
REQ-002 Parameter WIDTH, default 16, counter/load width in bits (8..32).
REQ-003 Parameter PRE_W, default 8, prescaler width in bits.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 psel, penable, pwrite  input  1 each  APB-style slave control.
REQ-007 paddr  input  8  byte address; bits[1:0] ignored.
REQ-008 pwdata  input  32  write data; bits above WIDTH ignored.
REQ-009 prdata  output  32  read data, zero-extended.
REQ-010 pready  output  1  tied 1 (no wait states).
REQ-011 pslverr  output  1  error on unmapped access.
REQ-012 irq  output  NUM_CH  per-channel interrupt, status AND ie.
REQ-013 irq_any  output  1  OR of irq.

Function
REQ-014 Access phase = psel&penable; writes commit on the clk edge ending the access phase; prdata combinational during access phase, 0 otherwise.
REQ-015 Map, channel n at base n*0x10: +0x0 CTRL (bit0 en, bit1 auto-reload, bit2 ie), +0x4 LOAD, +0x8 COUNT (RO, writes ignored), +0xC STATUS (bit0 intr, write-1-to-clear); global PRESCALE at NUM_CH*0x10.
REQ-016 pslverr=1 in access phase for any address outside the map; unmapped write has no effect, read returns 0.
REQ-017 Shared prescaler: tick pulses for one cycle every PRESCALE+1 clocks (PRESCALE=0 -> tick every cycle); write to PRESCALE restarts the prescale count at 0.
REQ-018 Per-channel FSM states IDLE, LOAD, RUN, DONE.
REQ-019 IDLE -> LOAD when en=1; LOAD copies LOAD register to count in one cycle, then -> RUN, or -> DONE with intr set if LOAD=0.
REQ-020 RUN: on tick with count>0, count decrements by 1; on tick with count=0, intr set and, if auto-reload, count<=LOAD and stay RUN, else -> DONE.
REQ-021 DONE holds count at 0; stays until en=0.
REQ-022 en=0 in any state -> IDLE next cycle; count frozen at current value; intr unchanged.
REQ-023 LOAD written during RUN affects only the next reload or next IDLE->LOAD pass, never the running count.
REQ-024 intr set and W1C in same cycle: set wins (intr=1).
REQ-025 Count arithmetic is WIDTH-bit unsigned; decrement never wraps below 0.
REQ-026 Channels fully independent except the shared tick.

Reset
REQ-027 reset=1 on posedge: all FSMs IDLE; CTRL, LOAD, COUNT, STATUS, PRESCALE, prescale counter = 0; irq, irq_any = 0.
REQ-028 Reset mid-count aborts immediately; no interrupt generated by the reset.
REQ-029 prdata, pslverr are 0 while reset asserted.

Structure
REQ-030 Package timer_pkg holds the channel-state enum, register offset constants and CTRL bit indices.
REQ-031 Sub-module timer_chan implements one channel FSM + counter + intr; timer_bank instantiates NUM_CH via generate and owns the bus decode and prescaler.

Verification
REQ-032 PRESCALE=0, ch0 LOAD=5, CTRL=0b101 -> COUNT 5,4,3,2,1,0 on successive cycles, intr/irq[0] rise one tick after COUNT=0, FSM DONE.
REQ-033 PRESCALE=3, ch1 LOAD=2, auto-reload -> COUNT changes every 4 clocks, irq[1] pulses-set every 12 clocks, COUNT reloads to 2.
REQ-034 ch2 running at COUNT=7, write CTRL en=0 -> COUNT holds 7, FSM IDLE; re-enable -> COUNT restarts from LOAD.
REQ-035 Cycle where ch0 intr sets and STATUS W1C 0x1 written -> STATUS reads 1 afterwards; next W1C clears to 0, irq_any falls.
REQ-036 Read 0xFC with NUM_CH=4 -> pslverr=1, prdata=0; LOAD=0 with en -> intr set immediately, FSM DONE.
REQ-037 reset asserted mid-count on all channels -> all registers 0, irq=0 next cycle.
